// File: rtl/xil_prim_pkg.sv
// Shared definitions for the primitive/macro library.
//   CNT_MAX_WIDTH  : widest counter the macros support.
//   cnt_dir_e      : direction encoding (CNT_DOWN=0, CNT_UP=1).
//   cnt_num_slices : number of 4-bit carry slices for a given width.
package xil_prim_pkg;

  localparam int CNT_MAX_WIDTH = 48;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // ceil(width / 4)
  function automatic int cnt_num_slices(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/counter_addsub_slice.sv
// 4-bit add/subtract stage of the slice carry chain.
//   a_i   : 4-bit operand A
//   b_i   : 4-bit operand B (inverted internally when sub_i=1)
//   sub_i : 1 = compute A + ~B + ci_i, 0 = compute A + B + ci_i
//   ci_i  : carry in from the previous slice
//   s_o   : 4-bit sum
//   co_o  : carry out to the next slice
module counter_addsub_slice
  import xil_prim_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sub_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [4:0] sum;

  assign sum  = {1'b0, a_i} + {1'b0, b_i ^ {4{sub_i}}} + {4'b0000, ci_i};
  assign s_o  = sum[3:0];
  assign co_o = sum[4];

endmodule

// File: rtl/counter_load_macro.sv
// Loadable up/down counter built on the slice carry chain.
// Registers the chain's sum and carry-out and adds load, enable,
// direction and terminal-count control. Priority: RST > LOAD > CE.
//   CLK       : rising-edge clock
//   RST       : synchronous reset, active-high
//   CE        : count enable
//   DIRECTION : 1 = count up by COUNT_BY, 0 = count down
//   LOAD      : synchronous load of LOAD_DATA (independent of CE)
//   LOAD_DATA : value to load
//   Q         : counter value
//   CO        : carry (up) / borrow (down) of the last count step
//   TC        : terminal count (all-ones when up, zero when down)
// Optional feature macro: COUNTER_LOAD_SATURATE_EN -- when defined the
// counter clamps at all-ones / zero instead of wrapping.
module counter_load_macro
  import xil_prim_pkg::*;
#(
  parameter int                    WIDTH_DATA  = 16,
  parameter int                    COUNT_BY    = 1,
  parameter int                    LATENCY     = 1,
  parameter logic [WIDTH_DATA-1:0] RESET_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  DIRECTION,
  input  logic                  LOAD,
  input  logic [WIDTH_DATA-1:0] LOAD_DATA,
  output logic [WIDTH_DATA-1:0] Q,
  output logic                  CO,
  output logic                  TC
);

  localparam int NS = cnt_num_slices(WIDTH_DATA);
  localparam int PW = NS * 4;
  localparam logic [WIDTH_DATA-1:0] STEP = WIDTH_DATA'(COUNT_BY);

  cnt_dir_e              dir;
  logic [WIDTH_DATA-1:0] cnt_q, cnt_d;
  logic                  co_q, co_d;
  logic [PW-1:0]         a_pad, b_pad, sum_pad;
  logic [NS:0]           carry;
  logic                  up_co, dn_bo, step_co;
  logic [WIDTH_DATA-1:0] step_val, step_next;
  logic                  tc_now;

  assign dir = cnt_dir_e'(DIRECTION);

  // Operands are zero-extended to a whole number of slices. Subtraction is
  // A + ~B + 1, so the chain's carry-in doubles as the subtract select.
  assign a_pad    = PW'(cnt_q);
  assign b_pad    = PW'(STEP);
  assign carry[0] = (dir == CNT_DOWN);

  for (genvar i = 0; i < NS; i++) begin : g_slice
    counter_addsub_slice u_slice (
      .a_i  (a_pad[4*i +: 4]),
      .b_i  (b_pad[4*i +: 4]),
      .sub_i(dir == CNT_DOWN),
      .ci_i (carry[i]),
      .s_o  (sum_pad[4*i +: 4]),
      .co_o (carry[i+1])
    );
  end

  // Carry at bit WIDTH_DATA. When the width fills the slices exactly it is
  // the chain carry-out. Otherwise it lands inside the padding: going up only
  // bit WIDTH_DATA can be set; going down a borrow turns every padding bit to
  // one and clears the chain carry-out.
  if (PW == WIDTH_DATA) begin : g_full
    assign up_co = carry[NS];
    assign dn_bo = ~carry[NS];
  end else begin : g_pad
    assign up_co = |{carry[NS], sum_pad[PW-1:WIDTH_DATA]};
    assign dn_bo = ~carry[NS] & (&sum_pad[PW-1:WIDTH_DATA]);
  end

  assign step_co  = (dir == CNT_UP) ? up_co : dn_bo;
  assign step_val = sum_pad[WIDTH_DATA-1:0];

`ifdef COUNTER_LOAD_SATURATE_EN
  // Clamp to the limit in the direction of travel on overflow/underflow.
  assign step_next = step_co ? ((dir == CNT_UP) ? {WIDTH_DATA{1'b1}} : '0)
                             : step_val;
`else
  assign step_next = step_val;
`endif

  always_comb begin
    cnt_d = cnt_q;
    co_d  = co_q;
    if (LOAD) begin
      cnt_d = LOAD_DATA;
      co_d  = 1'b0;
    end else if (CE) begin
      cnt_d = step_next;
      co_d  = step_co;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= RESET_VALUE;
      co_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      co_q  <= co_d;
    end
  end

  assign tc_now = (dir == CNT_UP) ? (&cnt_q) : ~(|cnt_q);

  if (LATENCY == 2) begin : g_lat2
    // Output stage updates every cycle regardless of CE; reset overwrites
    // whatever is in flight.
    logic [WIDTH_DATA-1:0] q_q;
    logic                  co_out_q, tc_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        q_q      <= RESET_VALUE;
        co_out_q <= 1'b0;
        tc_q     <= 1'b0;
      end else begin
        q_q      <= cnt_q;
        co_out_q <= co_q;
        tc_q     <= tc_now;
      end
    end

    assign Q  = q_q;
    assign CO = co_out_q;
    assign TC = tc_q;
  end else begin : g_lat1
    assign Q  = cnt_q;
    assign CO = co_q;
    assign TC = tc_now;
  end

endmodule

// File: tb/tb_counter_load_macro.sv
// Bench for counter_load_macro: four instances with different step, width
// and latency share one stimulus stream and are checked every cycle against
// an arithmetic model, plus hand-computed expectations at key points.
module tb_counter_load_macro;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [7:0] ld = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  // inst 0: W8 step1 lat1 | inst 1: W8 step3 lat1
  // inst 2: W8 step1 lat2 | inst 3: W6 step4 lat1 (padded slice)
  logic [7:0] q0, q1, q2;
  logic [5:0] q3;
  logic [3:0] co_w, tc_w;

  counter_load_macro #(.WIDTH_DATA(8), .COUNT_BY(1), .LATENCY(1), .RESET_VALUE(8'h5A)) u_a (
    .CLK(clk), .RST(rst), .CE(ce), .DIRECTION(dir), .LOAD(load), .LOAD_DATA(ld),
    .Q(q0), .CO(co_w[0]), .TC(tc_w[0]));
  counter_load_macro #(.WIDTH_DATA(8), .COUNT_BY(3), .LATENCY(1), .RESET_VALUE(8'h5A)) u_b (
    .CLK(clk), .RST(rst), .CE(ce), .DIRECTION(dir), .LOAD(load), .LOAD_DATA(ld),
    .Q(q1), .CO(co_w[1]), .TC(tc_w[1]));
  counter_load_macro #(.WIDTH_DATA(8), .COUNT_BY(1), .LATENCY(2), .RESET_VALUE(8'h5A)) u_c (
    .CLK(clk), .RST(rst), .CE(ce), .DIRECTION(dir), .LOAD(load), .LOAD_DATA(ld),
    .Q(q2), .CO(co_w[2]), .TC(tc_w[2]));
  counter_load_macro #(.WIDTH_DATA(6), .COUNT_BY(4), .LATENCY(1), .RESET_VALUE(6'h15)) u_d (
    .CLK(clk), .RST(rst), .CE(ce), .DIRECTION(dir), .LOAD(load), .LOAD_DATA(ld[5:0]),
    .Q(q3), .CO(co_w[3]), .TC(tc_w[3]));

  logic [7:0] dq [NI];
  assign dq[0] = q0;
  assign dq[1] = q1;
  assign dq[2] = q2;
  assign dq[3] = {2'b00, q3};

  // ---------------- model ----------------
  int         m_w   [NI] = '{8, 8, 8, 6};
  int         m_st  [NI] = '{1, 3, 1, 4};
  int         m_lat [NI] = '{1, 1, 2, 1};
  logic [7:0] m_rv  [NI] = '{8'h5A, 8'h5A, 8'h5A, 8'h15};

  logic [7:0] m_cnt [NI];
  logic       m_co  [NI];
  logic [7:0] p_q   [NI];
  logic       p_co  [NI];
  logic       p_tc  [NI];
  logic       m_valid = 1'b0;

  function automatic longint unsigned mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic m_tc(input logic [7:0] c, input logic up, input int w);
    return up ? (longint'(c) == mask_of(w)) : (c == 8'h00);
  endfunction

  // Returns {carry/borrow, next value} for one enabled step.
  function automatic logic [8:0] m_step(input logic [7:0] c, input logic up,
                                        input int w, input int st);
    longint unsigned mk, s, r, v;
    logic            k;
    mk = mask_of(w);
    s  = longint'(st) & mk;
    if (up) begin
      r = longint'(c) + s;
      k = r > mk;
      v = r & mk;
    end else begin
      k = longint'(c) < s;
      v = (longint'(c) - s) & mk;
    end
`ifdef COUNTER_LOAD_SATURATE_EN
    if (k) v = up ? mk : 64'd0;
`endif
    return {k, v[7:0]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [8:0] nx;
      nx = m_step(m_cnt[i], dir, m_w[i], m_st[i]);
      if (rst) begin
        m_cnt[i] <= m_rv[i];
        m_co[i]  <= 1'b0;
        p_q[i]   <= m_rv[i];
        p_co[i]  <= 1'b0;
        p_tc[i]  <= 1'b0;
      end else begin
        p_q[i]  <= m_cnt[i];
        p_co[i] <= m_co[i];
        p_tc[i] <= m_tc(m_cnt[i], dir, m_w[i]);
        if (load) begin
          m_cnt[i] <= ld & 8'(mask_of(m_w[i]));
          m_co[i]  <= 1'b0;
        end else if (ce) begin
          m_cnt[i] <= nx[7:0];
          m_co[i]  <= nx[8];
        end
      end
    end
    if (rst) m_valid <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NI; i++) begin
        logic [7:0] eq;
        logic       eco, etc;
        if (m_lat[i] == 2) begin
          eq = p_q[i]; eco = p_co[i]; etc = p_tc[i];
        end else begin
          eq = m_cnt[i]; eco = m_co[i]; etc = m_tc(m_cnt[i], dir, m_w[i]);
        end
        chk($sformatf("model_q[%0d]", i),  64'(dq[i]),    64'(eq));
        chk($sformatf("model_co[%0d]", i), 64'(co_w[i]),  64'(eco));
        chk($sformatf("model_tc[%0d]", i), 64'(tc_w[i]),  64'(etc));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic l, input logic c,
                     input logic d, input logic [7:0] data);
    rst = r; load = l; ce = c; dir = d; ld = data;
    @(posedge clk);
    #2;
  endtask

  logic [12:0] mix [16] = '{
    {1'b0, 1'b1, 1'b0, 1'b0, 8'h03}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
    {1'b0, 1'b0, 1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
    {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}, {1'b0, 1'b0, 1'b0, 1'b1, 8'h00},
    {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
    {1'b0, 1'b1, 1'b0, 1'b1, 8'hFD}, {1'b0, 1'b0, 1'b1, 1'b1, 8'h00},
    {1'b0, 1'b0, 1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
    {1'b0, 1'b1, 1'b1, 1'b1, 8'h3F}, {1'b0, 1'b0, 1'b1, 1'b1, 8'h00},
    {1'b0, 1'b0, 1'b0, 1'b0, 8'h00}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}
  };

  initial begin
    // Reset held for two cycles with CE=1
    cyc(1, 0, 1, 1, 8'h00);
    cyc(1, 0, 1, 1, 8'h00);
    chk("rst_q",    64'(q0), 64'h5A);
    chk("rst_co",   64'(co_w[0]), 64'h0);
    chk("rst_tc",   64'(tc_w[0]), 64'h0);
    chk("rst_q_l2", 64'(q2), 64'h5A);
    chk("rst_q_w6", 64'(q3), 64'h15);

    // Up wrap
    cyc(0, 1, 0, 1, 8'hFE);
    chk("load_fe", 64'(q0), 64'hFE);
    chk("lat2_old", 64'(q2), 64'h5A);
    cyc(0, 0, 1, 1, 8'h00);
    chk("up_ff_q",  64'(q0), 64'hFF);
    chk("up_ff_tc", 64'(tc_w[0]), 64'h1);
    chk("up_ff_co", 64'(co_w[0]), 64'h0);
    chk("step3_wrap_q",  64'(q1), 64'h01);
    chk("step3_wrap_co", 64'(co_w[1]), 64'h1);
`ifdef COUNTER_LOAD_SATURATE_EN
    chk("sat_q",  64'(q3), 64'h3F);
    chk("sat_co", 64'(co_w[3]), 64'h1);
`else
    chk("w6_wrap_q",  64'(q3), 64'h02);
    chk("w6_wrap_co", 64'(co_w[3]), 64'h1);
`endif
    cyc(0, 0, 1, 1, 8'h00);
    chk("up_00_q",  64'(q0), 64'h00);
    chk("up_00_co", 64'(co_w[0]), 64'h1);
`ifdef COUNTER_LOAD_SATURATE_EN
    chk("sat_hold_q",  64'(q3), 64'h3F);
    chk("sat_hold_co", 64'(co_w[3]), 64'h1);
`endif
    cyc(0, 0, 1, 1, 8'h00);
    chk("up_01_q",  64'(q0), 64'h01);
    chk("up_01_co", 64'(co_w[0]), 64'h0);

    // Down by 3 across zero
    cyc(0, 1, 0, 0, 8'h02);
    cyc(0, 0, 1, 0, 8'h00);
    chk("dn_ff_q",  64'(q1), 64'hFF);
    chk("dn_ff_co", 64'(co_w[1]), 64'h1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("dn_fc_q",  64'(q1), 64'hFC);
    chk("dn_fc_co", 64'(co_w[1]), 64'h0);

    // Priority
    cyc(0, 1, 1, 1, 8'h10);
    chk("ld_ce_q",  64'(q0), 64'h10);
    chk("ld_ce_co", 64'(co_w[0]), 64'h0);
    cyc(1, 1, 1, 1, 8'h33);
    chk("rst_ld_q",    64'(q0), 64'h5A);
    chk("rst_ld_q_l2", 64'(q2), 64'h5A);

    // Latency 2
    cyc(0, 1, 0, 1, 8'h20);
    chk("l2_load_edge", 64'(q2), 64'h5A);
    cyc(0, 0, 1, 1, 8'h00);
    chk("l2_q20", 64'(q2), 64'h20);
    cyc(0, 0, 1, 1, 8'h00);
    chk("l2_q21", 64'(q2), 64'h21);
    cyc(1, 0, 1, 1, 8'h00);
    chk("l2_rst_q",  64'(q2), 64'h5A);
    chk("l2_rst_co", 64'(co_w[2]), 64'h0);

    // Mixed directed sequence covered by the per-cycle model compare
    for (int i = 0; i < 16; i++)
      cyc(mix[i][12], mix[i][11], mix[i][10], mix[i][9], mix[i][7:0]);
    cyc(0, 0, 0, 1, 8'h00);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
